// File: rtl/e_calc.sv
// e_calc: computes Euler's number as sum(1/k!) in Q4.396 fixed point.
// term(k) = term(k-1)/k via a bit-serial restoring divider working in place
// on the term register; each new term is added to a running sum.
// Optional build macro: E_CALC_RESTART_EN -- when defined, start during a
// running computation (DIV/ACC) aborts it and begins a fresh one.
module e_calc #(
  parameter int GUARD_BITS = 8,
  parameter int KMAX       = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         done,
  output logic [399:0] ans
);

  localparam int W  = 400 + GUARD_BITS;   // internal word width
  localparam int FB = 396 + GUARD_BITS;   // internal fraction bits
  localparam int CW = $clog2(W + 1);      // divider bit counter width

  localparam logic [W-1:0]  ONE    = {3'b000, 1'b1, {FB{1'b0}}};
  localparam logic [6:0]    KMAX_K = 7'(KMAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [2:0] {IDLE, INIT, DIV, ACC, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_term;   // dividend in, quotient out (shifted in place)
  logic [W-1:0]    r_sum;
  logic [6:0]      r_k;
  logic [6:0]      r_rem;    // partial remainder, always < k
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [399:0]    r_ans;

  logic [7:0]      w_trial;
  logic            w_ge;
  logic [6:0]      w_rem_nxt;
  logic [W-1:0]    w_sum_nxt;
  logic            w_last;
  logic            w_restart;

  // one restoring-divide step: bring down the term MSB, subtract k if it fits
  assign w_trial   = {r_rem, r_term[W-1]};
  assign w_ge      = (w_trial >= {1'b0, r_k});
  assign w_rem_nxt = w_ge ? 7'(w_trial - {1'b0, r_k}) : w_trial[6:0];

  // sum stays below 3, so this add never wraps
  assign w_sum_nxt = r_sum + r_term;
  assign w_last    = (r_term == '0) || (r_k == KMAX_K);

`ifdef E_CALC_RESTART_EN
  assign w_restart = start;
`else
  assign w_restart = 1'b0;
`endif

  // control FSM plus datapath registers; all outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_term  <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ans   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= INIT;
        end
        INIT: begin
          r_term  <= ONE;
          r_sum   <= ONE;
          r_k     <= 7'd1;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_state <= DIV;
        end
        DIV: begin
          if (w_restart) begin
            r_state <= INIT;
          end else begin
            r_term <= {r_term[W-2:0], w_ge};
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) r_state <= ACC;
          end
        end
        ACC: begin
          if (w_restart) begin
            r_state <= INIT;
          end else begin
            r_sum <= w_sum_nxt;
            if (w_last) begin
              // guard bits are simply truncated away
              r_ans   <= w_sum_nxt[W-1 -: 400];
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_k     <= r_k + 7'd1;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= DIV;
            end
          end
        end
        DONE: begin
          if (start) r_state <= INIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done = r_done;
  assign ans  = r_ans;

endmodule

// File: tb/tb_e_calc.sv
// tb_e_calc: scoreboard bench for e_calc. Golden e is computed here with a
// wider (Q4.476) series, then truncated to Q4.396.
module tb_e_calc;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic [399:0] ans;

  always #5 clk = ~clk;

  e_calc dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .done  (done),
    .ans   (ans)
  );

  // 82 series steps (term 82 truncates to zero), each W divide cycles + 1 ACC,
  // plus the INIT cycle; counted from the edge after the sampling edge.
  localparam int LAT = 1 + 82 * (400 + 8 + 1);
  localparam int LIM = 40000;

  int           n_err = 0;
  int           n_chk = 0;
  logic [399:0] exp_q [$];
  logic [399:0] gold;
  logic [399:0] ans_prev;
  int           lat, c, s2, n_hi, n_lo, n_chg;

  task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [399:0] golden();
    logic [479:0] t, s;
    t = 480'(1) << 476;
    s = t;
    for (int k = 1; k < 200; k++) begin
      t = t / 480'(k);
      s = s + t;
    end
    return s[479:80];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic sb_pop();
    logic [399:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 400'(0), 400'(1));
    end else begin
      e = exp_q.pop_front();
      chk("ans_range", 400'((e - ans) <= 400'd1), 400'(1));
      chk("ans_top64", 400'(ans[399:336]), 400'(64'h2B7E151628AED2A6));
      chk("ans_int", 400'(ans[399:396]), 400'(4'h2));
    end
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    gold  = golden();
    rst   = 1'b1;
    start = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_done", 400'(done), 400'(0));
    chk("rst_ans", ans, 400'(0));

    // rst and start together: rst wins, FSM stays idle
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    chk("rs_done", 400'(done), 400'(0));
    n_hi = 0;
    repeat (500) begin cyc(); if (done) n_hi++; end
    chk("rs_idle", 400'(n_hi), 400'(0));

    // first full computation; exact latency also proves it started from IDLE
    exp_q.push_back(gold);
    pulse_start();
    lat = 0;
    do begin cyc(); lat++; end while (!done && lat < LIM);
    chk("run1_lat", 400'(lat), 400'(LAT));
    chk("run1_done", 400'(done), 400'(1));
    if (done) sb_pop();

    // hold in DONE with start low
    ans_prev = ans;
    n_lo = 0; n_chg = 0;
    repeat (1000) begin
      cyc();
      if (!done) n_lo++;
      if (ans !== ans_prev) n_chg++;
    end
    chk("hold_done", 400'(n_lo), 400'(0));
    chk("hold_ans", 400'(n_chg), 400'(0));

    // second run with an extra start pulse about 3000 cycles in
    exp_q.push_back(gold);
    pulse_start();
    cyc();
    c = 1; s2 = 0; n_chg = 0;
    chk("done_drop", 400'(done), 400'(0));
    while (!done && c < LIM + 4000) begin
      if (c == 3000) start = 1'b1;
      cyc();
      c++;
      if (start) begin start = 1'b0; s2 = c; end
      if (!done && ans !== ans_prev) n_chg++;
    end
`ifdef E_CALC_RESTART_EN
    chk("run2_lat", 400'(c - s2), 400'(LAT));
`else
    chk("run2_lat", 400'(c), 400'(LAT));
`endif
    chk("recalc_ans_hold", 400'(n_chg), 400'(0));
    chk("run2_done", 400'(done), 400'(1));
    if (done) sb_pop();

    // reset in the middle of a computation
    pulse_start();
    repeat (4999) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_done", 400'(done), 400'(0));
    chk("mid_rst_ans", ans, 400'(0));
    n_hi = 0;
    repeat (1000) begin cyc(); if (done) n_hi++; end
    chk("mid_rst_stay", 400'(n_hi), 400'(0));

    chk("sb_empty", 400'(exp_q.size()), 400'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/e_calc.md
E_CALC -- requirements
Module: e_calc

Interface
REQ-001 The module SHALL have parameter GUARD_BITS, default 8: extra fraction bits carried internally below the ans LSB.
REQ-002 The module SHALL have parameter KMAX, default 127: largest series index k; it SHALL fit in a 7-bit counter.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start SHALL be an input, 1 bit: request to compute, sampled each rising edge.
REQ-006 Port done SHALL be an output, 1 bit: result valid, level-held.
REQ-007 Port ans SHALL be an output, 400 bits: e in unsigned fixed point Q4.396 (ans[399:396] integer, ans[395:0] fraction).

Function
REQ-008 The block SHALL compute e = sum of 1/k! for k=0.. by iterating term(k) = term(k-1)/k, starting from term(0)=1.0.
REQ-009 Internal term and sum registers SHALL be 400+GUARD_BITS bits wide, in Q4.(396+GUARD_BITS) format.
REQ-010 Division by k SHALL be a sequential restoring divider with 7-bit divisor, one quotient bit per cycle, MSB first, truncating (remainder discarded).
REQ-011 The state machine SHALL have states IDLE, INIT, DIV, ACC and DONE.
REQ-012 In IDLE, start=1 SHALL move to INIT; start=0 SHALL remain in IDLE.
REQ-013 INIT SHALL set term=1.0, sum=1.0 and k=1, clear done, then move to DIV.
REQ-014 DIV SHALL take exactly 400+GUARD_BITS cycles to produce term/k, then move to ACC.
REQ-015 ACC SHALL add the new term to sum in one cycle; wrap-around cannot occur, since sum < 3.
REQ-016 After ACC, the FSM SHALL go to DONE if the new term is zero or k == KMAX; otherwise it SHALL increment k and return to DIV.
REQ-017 On entering DONE, ans SHALL load sum[top 400 bits], with the guard bits truncated, and done SHALL go to 1 in the same cycle.
REQ-018 In DONE, done and ans SHALL hold until the next start; start=1 in DONE SHALL go to INIT, which clears done on the next edge.
REQ-019 ans SHALL change only on entry to DONE and SHALL hold its last value during a recomputation.
REQ-020 With default parameters, ans SHALL equal F or F-1, where F = floor(e * 2^396); all rounding errors are downward and total fewer than 2^GUARD_BITS internal ulps.
REQ-021 Total latency from the start sample to done=1 SHALL be fewer than 40000 cycles with defaults (about 80 terms times 410 cycles).

Reset
REQ-022 rst=1 SHALL force IDLE, done=0, ans=0, and term, sum and k to 0 on the next rising edge, regardless of state.
REQ-023 Reset in the middle of a computation SHALL abandon it; done SHALL not assert until a new start.
REQ-024 rst SHALL have priority over start when both are high.

Configuration
REQ-025 Macro E_CALC_RESTART_EN SHALL select how start is handled while a computation is running.
REQ-026 With E_CALC_RESTART_EN defined, start=1 in DIV or ACC SHALL return the FSM to INIT, abort the current computation and begin a fresh one; ans SHALL be unchanged.
REQ-027 Without E_CALC_RESTART_EN, start SHALL be ignored in INIT, DIV and ACC.

Verification
REQ-028 Reset for 2 cycles, then a 1-cycle start pulse -> done rises within 40000 cycles; ans[399:336] = 0x2B7E151628AED2A6; ans[399:396] = 0x2.
REQ-029 Full result check -> ans equals floor(e*2^396) or that value minus 1, compared against a golden value computed offline.
REQ-030 After done, hold start=0 for 1000 cycles -> done stays 1 and ans stays unchanged; a second start pulse -> done drops, then reasserts with an identical ans.
REQ-031 Assert rst about 5000 cycles into a computation -> next edge gives done=0, ans=0; with no further start, done stays 0.
REQ-032 Start pulse at about cycle 3000 of a run -> with E_CALC_RESTART_EN, done latency is measured from the second pulse; without the macro, from the first pulse; final ans is the same in both builds.
REQ-033 rst and start both high for 1 cycle -> FSM stays in IDLE and done stays 0.
